// File: rtl/dac_direct_pkg.sv
// Shared types and widths for the direct-mode DAC sample path.
// Words are 128-bit RTO outputs, beats are 256-bit RFDC transfers.
package dac_direct_pkg;
  localparam int SAMPLE_W = 16;
  localparam int HALF_W   = 128;
  localparam int BEAT_W   = 256;
  localparam int UCNT_W   = 16;

  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/direct_beat_fifo.sv
// Synchronous beat FIFO with a combinational head read.
// A push into a full FIFO is taken only when a pop frees a slot.
module direct_beat_fifo
  import dac_direct_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  beat_t         din,
  output beat_t         dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  beat_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dac_direct_streamer.sv
// Direct-mode DAC streamer: packs RTO word pairs into RFDC beats,
// buffers them and tracks overflow/underrun conditions.
module dac_direct_streamer
  import dac_direct_pkg::*;
#(
  parameter  int AXIS_DATA_WIDTH = 256,
  parameter  int FIFO_DEPTH      = 16,
  parameter  bit HOLD_LAST       = 1'b0,
  localparam int LW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       counter_matched,
  input  logic [HALF_W-1:0]          rto_in,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       half_pending,
  output logic [LW-1:0]              fifo_level,
  output logic                       overflow_error,
  output logic                       underrun_error,
  output logic [UCNT_W-1:0]          underrun_count
);

  if (AXIS_DATA_WIDTH != BEAT_W || FIFO_DEPTH < 4) begin : g_bad_cfg
    $error("dac_direct_streamer: unsupported width or depth");
  end

  logic              half_q;
  logic [HALF_W-1:0] low_q;
  logic              out_valid_q;
  beat_t             out_data_q;
  logic              started_q;

  logic              accept;
  logic              beat_done;
  logic              load;
  logic              consume;
  logic              drop;
  logic              underrun;
  beat_t             fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept    = counter_matched & enable & ~flush;
  assign beat_done = accept & half_q;
  assign consume   = out_valid_q & enable & m_axis_tready;
  assign load      = enable & ~fifo_empty
                   & (~out_valid_q | m_axis_tready);
  assign drop      = beat_done & fifo_full & ~load;
  assign underrun  = enable & started_q & m_axis_tready
                   & ~out_valid_q;

  direct_beat_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (beat_done),
    .pop   (load),
    .din   ({rto_in, low_q}),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Half pointer and low-half capture for beat packing.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      half_q <= 1'b0;
      low_q  <= '0;
    end else if (accept) begin
      if (!half_q) low_q <= rto_in;
      half_q <= ~half_q;
    end
  end

  // Output register; data is kept after consumption for hold-last.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fifo_dout;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  // Underruns only count once the stream has actually begun.
  always_ff @(posedge clk) begin
    if (reset || flush) started_q <= 1'b0;
    else if (consume)   started_q <= 1'b1;
  end

  // Sticky error flags and saturating starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_error <= 1'b0;
      underrun_error <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (drop) overflow_error <= 1'b1;
      if (underrun) begin
        underrun_error <= 1'b1;
        if (underrun_count != '1)
          underrun_count <= underrun_count + 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = enable
                       & (out_valid_q | (HOLD_LAST & started_q));
  assign half_pending  = half_q;

endmodule

// File: doc/dac_direct_streamer.md
# dac_direct_streamer

Direct-mode sample path of the DAC controller: consumes the 128-bit words released by the RTO core on each `counter_matched` pulse, pairs consecutive words into 256-bit RFDC AXI-Stream beats, buffers them in a small FIFO and drives them to the RFDC DAC with a tvalid/tready handshake. It sits between the RTO core output and the `dac_mode` output mux, on the direct (`dac_mode = 1`) leg. Underruns and overflows are counted and flagged for software.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 256, beat width; fixed at 2 × 128.
- `FIFO_DEPTH`, 16, beat FIFO depth; power of two, minimum 4.
- `HOLD_LAST`, 0, 1 = re-present the last beat with tvalid high on underrun.

Ports:
- `clk`  in  1  single clock, the AXI clock domain.
- `reset`  in  1  synchronous, active-high; clears all state.
- `enable`  in  1  direct mode selected (driven from `dac_mode`).
- `flush`  in  1  synchronous clear of the data path; error state is kept.
- `counter_matched`  in  1  one-cycle strobe: `rto_in` is valid.
- `rto_in`  in  128  eight 16-bit samples; sample 0 in [15:0].
- `m_axis_tdata`  out  256  beat to the RFDC.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  RFDC accepts the beat.
- `half_pending`  out  1  low half captured, high half awaited.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  beats held in the FIFO, excluding the output register.
- `overflow_error`  out  1  sticky; a beat was dropped.
- `underrun_error`  out  1  sticky; the RFDC was starved.
- `underrun_count`  out  16  number of starved cycles, saturating.

## Operation
- Packing:
  - The first accepted word after reset or flush is the low half and goes to tdata[127:0].
  - The next accepted word is the high half and goes to tdata[255:128]; it completes the beat.
  - A word is accepted when `counter_matched & enable & ~flush`. Words arriving while `enable` is low are discarded and do not advance the half pointer.
- FIFO write on beat completion:
  - The write succeeds if `fifo_level < FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the beat is dropped, `overflow_error` is set and the half pointer returns to low.
- Output register:
  - Loaded from the FIFO head whenever it is empty or being consumed (`tvalid & tready`) and the FIFO is non-empty.
  - `m_axis_tvalid` is the register's valid bit gated by `enable`.
  - tdata stays stable while `tvalid & ~tready`.
- Started flag: set by the first completed handshake after reset or flush.
- Underrun: a cycle with `enable & started & tready` and an empty output register.
  - `underrun_count` increments by 1 per such cycle and saturates at 16'hFFFF.
  - `underrun_error` is set.
  - With `HOLD_LAST = 1`, the last transmitted beat is re-presented with tvalid = 1. The cycle still counts as an underrun. Repeated beats are not popped.
- `enable` low:
  - tvalid is forced to 0 and no pops occur.
  - FIFO and output register contents are retained.
  - No underruns are counted.
- `flush`:
  - Clears the FIFO, the output register, the half pointer and the started flag within the same cycle.
  - Does not clear the error flags or the counter.
  - Flush wins over a simultaneous `counter_matched`; that word is lost.
- `reset`: clears everything, including the error flags and the counter.

## Timing
- Reset values: tdata 0, tvalid 0, half_pending 0, fifo_level 0, overflow_error 0, underrun_error 0, underrun_count 0.
- Latency from the completing strobe in cycle N, with the FIFO empty and the register empty:
  - FIFO write registered at the end of N; `fifo_level` = 1 in N+1.
  - Register loaded at the end of N+1; tvalid = 1 in N+2 and `fifo_level` returns to 0.
- Throughput: one beat per cycle when the FIFO is non-empty and tready stays high.
- Sustained input rate is at most one beat per two strobes.
- `half_pending` rises in the cycle after the low-half strobe and falls in the cycle after the high-half strobe.

## Structure
- Package `dac_direct_pkg`:
  - `SAMPLE_W` = 16, `HALF_W` = 128, `BEAT_W` = 256.
  - `typedef logic [BEAT_W-1:0] beat_t`.
  - Underrun counter width.
- Sub-module `direct_beat_fifo`:
  - Synchronous FIFO of `beat_t` with parameter `FIFO_DEPTH`.
  - Ports: push, pop, clear, level, full, empty.
  - The same-cycle push-and-pop rule is implemented inside it.
- Top level holds the packer, the output register, the started flag and the error logic.

## Test plan
- **Basic packing:** reset, enable = 1, tready = 1; strobe A = 128'h…0001, then B = 128'h…0002 → tvalid in the cycle after `fifo_level` is 1, with tdata = {B, A}, for exactly one cycle. underrun_count then increments each cycle while the bench waits.
- **Backpressure and overflow:** tready = 0; send 2·FIFO_DEPTH + 4 words = FIFO_DEPTH + 2 beats.
  - Expect 1 beat in the register, `fifo_level` = 16 and overflow_error = 1.
  - With tready = 1, exactly 17 beats drain in order.
- **Full plus simultaneous pop:** FIFO full, tready = 1, and a completing strobe in the same cycle → beat accepted, `fifo_level` stays at 16, overflow_error stays 0.
- **Flush mid-beat:** strobe the low half only, then assert flush with a strobe in the same cycle.
  - half_pending = 0, FIFO empty, tvalid = 0, error flags unchanged.
  - The next two words form a beat.
- **Underrun with HOLD_LAST = 1:** send one beat and consume it, then hold tready = 1 for 10 cycles with no input → tdata is repeated with tvalid = 1, underrun_count = 10, underrun_error = 1. A further reset → counter 0.
- **Enable gating:** enable = 0 while 4 words are strobed → half_pending = 0, fifo_level = 0, tvalid = 0, no underruns counted.
